fifo_arbitro_rr: RTL and testbench

//   Controller/arbiter that drains N_FIFOS source FIFO instances round-robin into one destination FIFO.

---
 rtl/fifo_arbitro_rr_pkg.sv | 21 ++
 rtl/fifo_arbitro_rr_prioridad_rr.sv | 29 ++
 rtl/fifo_arbitro_rr.sv | 145 ++++++++++++++
 tb/tb_fifo_arbitro_rr.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arbitro_rr_pkg.sv
// Shared types and constants for the round-robin FIFO drain arbiter.
// Provides FSM state encoding, default sizes and an index-width helper.
package fifo_arbitro_rr_pkg;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } estado_t;

    localparam int DATA_WIDTH_DEF = 12;
    localparam int N_FIFOS_DEF    = 4;

    // Width of a lane index; at least one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_arbitro_rr_prioridad_rr.sv
// Combinational round-robin picker: first requesting lane after last.
// Ports: req (request vector), last (previous winner), winner, valid.
module prioridad_rr #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] winner,
    output logic          valid
);

    logic [IW-1:0] idx;

    // Walk from farthest to nearest so the nearest requester wins.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int k = N; k >= 1; k--) begin
            idx = IW'((int'(last) + k) % N);
            if (req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_arbitro_rr.sv
// Drains N_FIFOS source FIFOs round-robin into one destination FIFO and
// programs the shared almost-empty/almost-full thresholds.
// Ports: clk, Reset (sync, active-low), Enable, init, umbral_*_in,
//   src_empty/src_data (sources), dst_almost_full/dst_full (destination),
//   src_read_enable, dst_write_enable, dst_data, interno_bajo/alto,
//   estado, idle, error.
module fifo_arbitro_rr
    import fifo_arbitro_rr_pkg::*;
#(
    parameter int         DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int         N_FIFOS    = N_FIFOS_DEF,
    parameter logic [2:0] BAJO_DEF   = 3'd1,
    parameter logic [2:0] ALTO_DEF   = 3'd6
) (
    input  logic                          clk,
    input  logic                          Reset,
    input  logic                          Enable,
    input  logic                          init,
    input  logic [2:0]                    umbral_bajo_in,
    input  logic [2:0]                    umbral_alto_in,
    input  logic [N_FIFOS-1:0]            src_empty,
    input  logic [N_FIFOS*DATA_WIDTH-1:0] src_data,
    input  logic                          dst_almost_full,
    input  logic                          dst_full,
    output logic [N_FIFOS-1:0]            src_read_enable,
    output logic                          dst_write_enable,
    output logic [DATA_WIDTH-1:0]         dst_data,
    output logic [2:0]                    interno_bajo,
    output logic [2:0]                    interno_alto,
    output logic [2:0]                    estado,
    output logic                          idle,
    output logic                          error
);

    localparam int IW = idx_w(N_FIFOS);

    estado_t       estado_q, estado_d;
    logic [2:0]    bajo_q, bajo_d;
    logic [2:0]    alto_q, alto_d;
    logic [IW-1:0] last_q, last_d;
    logic [IW-1:0] lane_q, lane_d;
    logic          pend_q, pend_d;
    logic          error_q, error_d;

    logic [N_FIFOS-1:0] req;
    logic [IW-1:0]      winner;
    logic               win_valid;

    assign req = ~src_empty;

    prioridad_rr #(
        .N  (N_FIFOS),
        .IW (IW)
    ) u_prioridad (
        .req    (req),
        .last   (last_q),
        .winner (winner),
        .valid  (win_valid)
    );

    always_comb begin
        estado_d         = estado_q;
        bajo_d           = bajo_q;
        alto_d           = alto_q;
        last_d           = last_q;
        lane_d           = lane_q;
        pend_d           = pend_q;
        error_d          = error_q;
        src_read_enable  = '0;
        dst_write_enable = 1'b0;
        if (Enable) begin
            unique case (estado_q)
                ST_RESET: estado_d = ST_INIT;
                ST_INIT: begin
                    bajo_d = umbral_bajo_in;
                    alto_d = umbral_alto_in;
                    if (!init) estado_d = ST_IDLE;
                end
                ST_IDLE: begin
                    if (init)        estado_d = ST_INIT;
                    else if (|req)   estado_d = ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (pend_q && dst_full) begin
                        // Overflow: drop the word, freeze until reset.
                        error_d  = 1'b1;
                        pend_d   = 1'b0;
                        estado_d = ST_ERROR;
                    end else begin
                        if (pend_q) begin
                            dst_write_enable = 1'b1;
                            pend_d           = 1'b0;
                        end
                        if (!dst_almost_full && win_valid) begin
                            src_read_enable[winner] = 1'b1;
                            last_d = winner;
                            lane_d = winner;
                            pend_d = 1'b1;
                        end
                        if (!(|req) && !pend_d) estado_d = ST_IDLE;
                    end
                end
                ST_ERROR: ;
                default: estado_d = ST_RESET;
            endcase
        end
    end

    // Source memories are read-registered: the granted word shows up on
    // its lane one cycle after the strobe, which is when we write it.
    always_comb begin
        dst_data = '0;
        for (int i = 0; i < N_FIFOS; i++) begin
            if (pend_q && lane_q == IW'(i))
                dst_data = src_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            estado_q <= ST_RESET;
            bajo_q   <= BAJO_DEF;
            alto_q   <= ALTO_DEF;
            last_q   <= IW'(N_FIFOS - 1);
            lane_q   <= '0;
            pend_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            bajo_q   <= bajo_d;
            alto_q   <= alto_d;
            last_q   <= last_d;
            lane_q   <= lane_d;
            pend_q   <= pend_d;
            error_q  <= error_d;
        end
    end

    assign interno_bajo = bajo_q;
    assign interno_alto = alto_q;
    assign estado       = estado_q;
    assign idle         = (estado_q == ST_IDLE);
    assign error        = error_q;

endmodule

// File: tb/tb_fifo_arbitro_rr.sv
// Self-checking bench for fifo_arbitro_rr: queue-based source FIFOs and
// a behavioural arbiter model compared against the DUT every cycle.
module tb_fifo_arbitro_rr;

    localparam int N  = 4;
    localparam int DW = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          Reset, Enable, init;
    logic [2:0]    ub, ua;
    logic [N-1:0]  src_empty;
    logic [N*DW-1:0] src_data;
    logic          dst_almost_full, dst_full;
    logic [N-1:0]  src_read_enable;
    logic          dst_write_enable;
    logic [DW-1:0] dst_data;
    logic [2:0]    interno_bajo, interno_alto, estado;
    logic          idle, error;

    fifo_arbitro_rr #(
        .DATA_WIDTH (DW),
        .N_FIFOS    (N),
        .BAJO_DEF   (3'd1),
        .ALTO_DEF   (3'd6)
    ) dut (
        .clk              (clk),
        .Reset            (Reset),
        .Enable           (Enable),
        .init             (init),
        .umbral_bajo_in   (ub),
        .umbral_alto_in   (ua),
        .src_empty        (src_empty),
        .src_data         (src_data),
        .dst_almost_full  (dst_almost_full),
        .dst_full         (dst_full),
        .src_read_enable  (src_read_enable),
        .dst_write_enable (dst_write_enable),
        .dst_data         (dst_data),
        .interno_bajo     (interno_bajo),
        .interno_alto     (interno_alto),
        .estado           (estado),
        .idle             (idle),
        .error            (error)
    );

    // Source FIFO contents and their registered read outputs.
    logic [DW-1:0] fq [N][$];
    logic [DW-1:0] out_reg [N];

    // Reference model state.
    int            m_st;
    int            m_last;
    logic [2:0]    m_bajo, m_alto;
    bit            m_pend, m_err;
    logic [DW-1:0] m_word;

    logic [N-1:0]  obs_rd;
    logic          obs_wr, obs_err;
    logic [2:0]    obs_st, obs_bajo, obs_alto;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      nm, act, exp, $time);
    endtask

    task automatic model_reset();
        m_st = 0; m_last = N - 1; m_bajo = 3'd1; m_alto = 3'd6;
        m_pend = 0; m_err = 0;
    endtask

    task automatic push(input int lane, input int cnt);
        for (int j = 0; j < cnt; j++)
            fq[lane].push_back(DW'($urandom));
    endtask

    task automatic cycle();
        int nst, nlast, w, pop_lane;
        bit npend, nerr, ewr, any;
        logic [2:0] nb, na;
        logic [N-1:0] erd;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            src_empty[i] = (fq[i].size() == 0);
            src_data[i*DW +: DW] = out_reg[i];
        end
        #1;
        nst = m_st; nlast = m_last; npend = m_pend; nerr = m_err;
        nb = m_bajo; na = m_alto; erd = '0; ewr = 0; pop_lane = -1;
        any = 0;
        for (int i = 0; i < N; i++) if (fq[i].size() != 0) any = 1;
        if (!Reset) begin
            nst = 0; nb = 3'd1; na = 3'd6; nlast = N - 1;
            npend = 0; nerr = 0;
        end else if (Enable) begin
            case (m_st)
                0: nst = 1;
                1: begin
                    nb = ub; na = ua;
                    if (!init) nst = 2;
                end
                2: begin
                    if (init) nst = 1;
                    else if (any) nst = 3;
                end
                3: begin
                    if (m_pend && dst_full) begin
                        nerr = 1; nst = 4; npend = 0;
                    end else begin
                        if (m_pend) begin ewr = 1; npend = 0; end
                        if (!dst_almost_full && any) begin
                            w = 0;
                            for (int k = 1; k <= N; k++) begin
                                w = (m_last + k) % N;
                                if (fq[w].size() != 0) break;
                            end
                            erd[w] = 1'b1; nlast = w; npend = 1;
                            pop_lane = w;
                        end
                        if (!any && !npend) nst = 2;
                    end
                end
                default: ;
            endcase
        end
        chk("estado", 32'(estado), 32'(m_st));
        chk("idle", 32'(idle), 32'(m_st == 2));
        chk("error", 32'(error), 32'(m_err));
        chk("src_read_enable", 32'(src_read_enable), 32'(erd));
        chk("dst_write_enable", 32'(dst_write_enable), 32'(ewr));
        chk("interno_bajo", 32'(interno_bajo), 32'(m_bajo));
        chk("interno_alto", 32'(interno_alto), 32'(m_alto));
        if (ewr) chk("dst_data", 32'(dst_data), 32'(m_word));
        obs_rd = src_read_enable; obs_wr = dst_write_enable;
        obs_err = error; obs_st = estado;
        obs_bajo = interno_bajo; obs_alto = interno_alto;
        @(posedge clk);
        #1;
        if (pop_lane >= 0) begin
            out_reg[pop_lane] = fq[pop_lane].pop_front();
            m_word = out_reg[pop_lane];
        end
        m_st = nst; m_last = nlast; m_pend = npend; m_err = nerr;
        m_bajo = nb; m_alto = na;
    endtask

    function automatic int lane_of(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    initial begin
        int glog[$];
        int wcnt, c2, cother;
        int exp_g[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        Reset = 0; Enable = 1; init = 0; ub = 0; ua = 0;
        dst_almost_full = 0; dst_full = 0;
        src_empty = '1; src_data = '0;
        for (int i = 0; i < N; i++) out_reg[i] = '0;
        model_reset();
        @(posedge clk); #1;

        // Reset and threshold programming.
        cycle(); cycle();
        chk("rst_estado", 32'(obs_st), 32'd0);
        chk("rst_bajo", 32'(obs_bajo), 32'd1);
        chk("rst_alto", 32'(obs_alto), 32'd6);
        Reset = 1; init = 1; ub = 3'd2; ua = 3'd5;
        cycle();
        chk("leave_reset", 32'(obs_st), 32'd0);
        cycle();
        chk("in_init", 32'(obs_st), 32'd1);
        init = 0;
        cycle(); cycle();
        chk("init_idle", 32'(obs_st), 32'd2);
        chk("init_bajo", 32'(obs_bajo), 32'd2);
        chk("init_alto", 32'(obs_alto), 32'd5);

        // Four lanes, two words each.
        for (int i = 0; i < N; i++) push(i, 2);
        wcnt = 0;
        for (int c = 0; c < 12; c++) begin
            cycle();
            if (obs_rd != '0) glog.push_back(lane_of(obs_rd));
            if (obs_wr) wcnt++;
        end
        chk("rr_grants", 32'(glog.size()), 32'd8);
        for (int i = 0; i < 8 && i < glog.size(); i++)
            chk("rr_order", 32'(glog[i]), 32'(exp_g[i]));
        chk("rr_writes", 32'(wcnt), 32'd8);
        chk("rr_idle", 32'(obs_st), 32'd2);

        // Single busy lane.
        push(2, 3);
        c2 = 0; cother = 0;
        for (int c = 0; c < 8; c++) begin
            cycle();
            if (obs_rd == 4'b0100) c2++;
            else if (obs_rd != '0) cother++;
        end
        chk("lane2_grants", 32'(c2), 32'd3);
        chk("lane2_other", 32'(cother), 32'd0);

        // Almost-full mid-burst.
        for (int i = 0; i < N; i++) push(i, 3);
        cycle(); cycle(); cycle();
        dst_almost_full = 1;
        cycle();
        chk("af_inflight_wr", 32'(obs_wr), 32'd1);
        chk("af_no_grant", 32'(obs_rd), 32'd0);
        cycle();
        chk("af_no_grant2", 32'(obs_rd), 32'd0);
        dst_almost_full = 0;
        cycle();
        chk("af_resume", 32'(obs_rd != '0), 32'd1);
        for (int c = 0; c < 14; c++) cycle();

        // Enable low mid-burst.
        for (int i = 0; i < N; i++) push(i, 2);
        cycle(); cycle(); cycle();
        Enable = 0;
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("en_off_strobes", 32'({obs_rd, obs_wr}), 32'd0);
        end
        Enable = 1;
        cycle();
        chk("en_back_write", 32'(obs_wr), 32'd1);
        for (int c = 0; c < 12; c++) cycle();

        // Randomised traffic.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0)
                push($urandom_range(0, N - 1), $urandom_range(1, 3));
            dst_almost_full = ($urandom_range(0, 4) == 0);
            Enable = ($urandom_range(0, 9) != 0);
            init = ($urandom_range(0, 19) == 0);
            ub = 3'($urandom); ua = 3'($urandom);
            cycle();
        end
        dst_almost_full = 0; Enable = 1; init = 0;
        for (int c = 0; c < 60; c++) cycle();
        chk("rand_drained", 32'(obs_st), 32'd2);

        // Overflow into ERROR.
        push(1, 4);
        cycle(); cycle();
        dst_full = 1;
        cycle();
        chk("ovf_no_write", 32'(obs_wr), 32'd0);
        cycle();
        chk("ovf_error", 32'(obs_err), 32'd1);
        chk("ovf_estado", 32'(obs_st), 32'd4);
        dst_full = 0;
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("err_strobes", 32'({obs_rd, obs_wr}), 32'd0);
        end
        chk("err_sticky", 32'(obs_err), 32'd1);
        Reset = 0;
        cycle();
        Reset = 1;
        cycle();
        chk("err_cleared", 32'(obs_err), 32'd0);
        chk("err_reset_st", 32'(obs_st), 32'd0);
        for (int c = 0; c < 12; c++) cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
